pll_cfg_seq: RTL

- Management-clock sequencer that reprograms the fractional PLL at run time: latches an M/N/C0/K configuration from the host, then issues the Avalon-MM write sequence to the PLL reconfiguration controller.
- The controller drives the PLL's 64-bit reconfig_to_pll bus; this block sits directly upstream of it.
- After starting reconfiguration, waits for the PLL lock to recover and reports done or timeout.
- Used for video/CPU clock switching, e.g. NTSC 42.954540 MHz.

---
 rtl/pll_cfg_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pll_cfg_seq.sv
// Run-time PLL reprogramming sequencer: latches an M/N/C0/K set, writes it to the
// reconfiguration controller over Avalon-MM, then waits for lock or timeout.
module pll_cfg_seq #(
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int SETTLE_CYCLES = 16,
    parameter int SKIP_ZERO_K   = 1
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        start,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_c0,
    input  logic [31:0] cfg_k,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_K, WR_START,
        WAIT_SETTLE, WAIT_LOCK, FIN_OK, FIN_ERR
    } state_t;

    localparam int             TW       = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TW-1:0]  T_MAX    = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0]  T_SETTLE = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]  T_LOCK   = TW'(LOCK_TIMEOUT - 1);

    state_t        state;
    state_t        nxt;
    logic          gap;
    logic [TW-1:0] timer;
    logic [17:0]   m_q, n_q, c0_q;
    logic [31:0]   k_q;
    logic [1:0]    lock_sync;
    logic          locked_s;
    logic [5:0]    nxt_addr;
    logic [31:0]   nxt_data;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) lock_sync <= 2'b00;
        else     lock_sync <= {lock_sync[0], pll_locked};
    end
    assign locked_s = lock_sync[1];

    // Successor of each write state and the address/data it will present.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        nxt      = IDLE;
        nxt_addr = 6'h00;
        nxt_data = 32'h0;
        case (state)
            WR_MODE:  nxt = WR_N;
            WR_N:     nxt = WR_M;
            WR_M:     nxt = WR_C0;
            WR_C0:    nxt = (SKIP_ZERO_K != 0 && k_q == 32'h0) ? WR_START : WR_K;
            WR_K:     nxt = WR_START;
            WR_START: nxt = WAIT_SETTLE;
            default:  nxt = IDLE;
        endcase
        case (nxt)
            WR_N:     begin nxt_addr = 6'h03; nxt_data = {14'b0, n_q}; end
            WR_M:     begin nxt_addr = 6'h04; nxt_data = {14'b0, m_q}; end
            WR_C0:    begin nxt_addr = 6'h05; nxt_data = {9'b0, 5'd0, c0_q}; end
            WR_K:     begin nxt_addr = 6'h07; nxt_data = k_q; end
            WR_START: begin nxt_addr = 6'h02; nxt_data = 32'h1; end
            default:  begin nxt_addr = 6'h00; nxt_data = 32'h0; end
        endcase
    end

    // NOTE: all state here uses non-blocking assignment; later assignments in the block override earlier defaults.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            gap            <= 1'b0;
            timer          <= '0;
            m_q            <= '0;
            n_q            <= '0;
            c0_q           <= '0;
            k_q            <= '0;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_writedata <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            if (timer != T_MAX) timer <= timer + TW'(1);
            case (state)
                IDLE: if (start) begin
                    m_q            <= cfg_m;
                    n_q            <= cfg_n;
                    c0_q           <= cfg_c0;
                    k_q            <= cfg_k;
                    state          <= WR_MODE;
                    busy           <= 1'b1;
                    gap            <= 1'b0;
                    mgmt_write     <= 1'b1;
                    mgmt_address   <= 6'h00;
                    mgmt_writedata <= 32'h0;
                end
                WR_MODE, WR_N, WR_M, WR_C0, WR_K, WR_START: begin
                    // Each write is a strobe phase (held through stalls) then one idle gap cycle.
                    if (!gap) begin
                        if (!mgmt_waitrequest) begin
                            mgmt_write     <= 1'b0;
                            mgmt_address   <= 6'h00;
                            mgmt_writedata <= 32'h0;
                            gap            <= 1'b1;
                        end
                    end else begin
                        gap   <= 1'b0;
                        state <= nxt;
                        if (nxt == WAIT_SETTLE) begin
                            timer <= '0;
                        end else begin
                            mgmt_write     <= 1'b1;
                            mgmt_address   <= nxt_addr;
                            mgmt_writedata <= nxt_data;
                        end
                    end
                end
                WAIT_SETTLE: if (timer == T_SETTLE) state <= WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= FIN_OK;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (timer == T_LOCK) begin
                        state       <= FIN_ERR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
